// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: sizing helpers shared by dp_ram and its read pipeline.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package dp_ram_pkg;

   // Deepest read pipeline the RAM supports.
   localparam int unsigned DP_RAM_MAX_RD_LAT = 2;

   // True when a requested read latency is one the RAM can build.
   function automatic bit rd_lat_legal(input int lat);
      return (lat >= 0) && (lat <= int'(DP_RAM_MAX_RD_LAT));
   endfunction

   // Index width for a word array of the given depth. A single-word array
   // still gets a 1-bit index so the array declaration stays legal.
   function automatic int idx_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// dp_ram_rd_pipe: dw-wide delay line of 0..2 stages with synchronous clear.
// Latency: depth cycles (depth 0 is a plain wire).
// Backpressure: none; a new word is accepted every cycle.
//
// Ports:
//   clk   - clock for all stages
//   rstn  - synchronous active-low clear of every stage
//   din   - word entering the line
//   dout  - word leaving the line, depth cycles later
module dp_ram_rd_pipe
   import dp_ram_pkg::*;
#(
   parameter int dw    = 32,
   parameter int depth = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [dw-1:0] din,
   output logic [dw-1:0] dout
);

   if (depth == 0) begin : g_wire
      assign dout = din;

      // Clock and clear have nothing to drive in the wire case.
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rstn;
   end else begin : g_reg
      logic [dw-1:0] stg_q [depth];
      logic [dw-1:0] stg_d [depth];

      always_comb begin
         stg_d[0] = din;
         for (int i = 1; i < depth; i++) begin
            stg_d[i] = stg_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (!rstn) begin
            for (int i = 0; i < depth; i++) begin
               stg_q[i] <= '0;
            end
         end else begin
            for (int i = 0; i < depth; i++) begin
               stg_q[i] <= stg_d[i];
            end
         end
      end

      assign dout = stg_q[depth-1];
   end

endmodule

// File: rtl/dp_ram.sv
// dp_ram: simple dual-port RAM, one write port and one read port, one clock.
// Latency: write visible the next cycle; read data rd_lat (0..2) cycles after raddr.
// Backpressure: none; both ports accept a new request every cycle.
//
// Ports:
//   clk    - sole clock, all state changes on the rising edge
//   rstn   - synchronous active-low reset (clears read pipeline, blocks writes)
//   we     - write enable
//   waddr  - write address; addresses >= max_size are dropped
//   din    - write data
//   raddr  - read address; addresses >= max_size read as zero
//   dout   - read data
module dp_ram
   import dp_ram_pkg::*;
#(
   parameter int aw       = 4,
   parameter int dw       = 32,
   parameter int max_size = 16,
   parameter int rd_lat   = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          we,
   input  logic [aw-1:0] waddr,
   input  logic [dw-1:0] din,
   input  logic [aw-1:0] raddr,
   output logic [dw-1:0] dout
);

   localparam int            IW     = idx_width(max_size);
   // Depth widened by one bit so 2^aw itself is representable.
   localparam logic [aw:0]   SIZE_W = (aw+1)'(max_size);

   if (!rd_lat_legal(rd_lat)) begin : g_bad_lat
      $error("dp_ram: rd_lat must be 0, 1 or 2");
   end
   if ((max_size < 1) || (max_size > (1 << aw))) begin : g_bad_size
      $error("dp_ram: max_size must be in 1..2**aw");
   end

   // Storage has no reset so it maps onto block or distributed RAM.
   logic [dw-1:0] mem_q [max_size];

   logic          wr_en_d;
   logic [IW-1:0] widx_d;
   logic          rd_in_range_d;
   logic [IW-1:0] ridx_d;
   logic [dw-1:0] rd_lookup_d;

   always_comb begin
      widx_d        = waddr[IW-1:0];
      ridx_d        = raddr[IW-1:0];
      // Out-of-range writes and any write during reset leave memory untouched.
      wr_en_d       = we && rstn && ({1'b0, waddr} < SIZE_W);
      rd_in_range_d = ({1'b0, raddr} < SIZE_W);
   end

   always_ff @(posedge clk) begin
      if (wr_en_d) begin
         mem_q[widx_d] <= din;
      end
   end

   // The range mux sits outside the array so the array stays a plain RAM.
   // Reading mem_q before the write edge commits gives read-first behaviour
   // for every latency.
   always_comb begin
      rd_lookup_d = '0;
      if (rd_in_range_d) begin
         rd_lookup_d = mem_q[ridx_d];
      end
   end

   dp_ram_rd_pipe #(
      .dw    (dw),
      .depth (rd_lat)
   ) u_rd_pipe (
      .clk  (clk),
      .rstn (rstn),
      .din  (rd_lookup_d),
      .dout (dout)
   );

endmodule

// File: tb/tb_dp_ram.sv
// tb_dp_ram: directed bench for dp_ram across read latencies 0/1/2 and a
// non-power-of-two depth. All four instances share one stimulus bus.
module tb_dp_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        we;
   logic [3:0]  waddr;
   logic [31:0] din;
   logic [3:0]  raddr;
   logic [31:0] dout0, dout1, dout2, dout10;

   int checks = 0;
   int errors = 0;

   dp_ram #(.aw(4), .dw(32), .max_size(16), .rd_lat(0)) u_lat0 (
      .clk(clk), .rstn(rstn), .we(we), .waddr(waddr), .din(din),
      .raddr(raddr), .dout(dout0));
   dp_ram #(.aw(4), .dw(32), .max_size(16), .rd_lat(1)) u_lat1 (
      .clk(clk), .rstn(rstn), .we(we), .waddr(waddr), .din(din),
      .raddr(raddr), .dout(dout1));
   dp_ram #(.aw(4), .dw(32), .max_size(16), .rd_lat(2)) u_lat2 (
      .clk(clk), .rstn(rstn), .we(we), .waddr(waddr), .din(din),
      .raddr(raddr), .dout(dout2));
   dp_ram #(.aw(4), .dw(32), .max_size(10), .rd_lat(1)) u_ms10 (
      .clk(clk), .rstn(rstn), .we(we), .waddr(waddr), .din(din),
      .raddr(raddr), .dout(dout10));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn  = 1'b0;
      we    = 1'b0;
      waddr = '0;
      din   = '0;
      raddr = '0;

      // Reset held two cycles: registered outputs read zero.
      tick();
      tick();
      check("reset_lat1", dout1, 32'h0);
      check("reset_lat2", dout2, 32'h0);
      check("reset_ms10", dout10, 32'h0);

      // Basic write then read of address 3.
      rstn  = 1'b1;
      we    = 1'b1;
      waddr = 4'd3;
      din   = 32'hDEADBEEF;
      tick();
      we    = 1'b0;
      raddr = 4'd3;
      #1;
      check("wr3_lat0", dout0, 32'hDEADBEEF);
      tick();
      check("wr3_lat1", dout1, 32'hDEADBEEF);
      check("wr3_ms10", dout10, 32'hDEADBEEF);
      tick();
      check("wr3_lat2", dout2, 32'hDEADBEEF);

      // Fill every address with 0x100+k (u_ms10 keeps only 0..9).
      for (int k = 0; k < 16; k++) begin
         we    = 1'b1;
         waddr = 4'(k);
         din   = 32'h100 + 32'(k);
         tick();
      end
      we = 1'b0;

      // Back-to-back read stream; each latency sees the same sequence shifted.
      for (int k = 0; k < 18; k++) begin
         raddr = (k < 16) ? 4'(k) : 4'd0;
         #1;
         if (k < 16)
            check($sformatf("sweep_lat0_%0d", k), dout0, 32'h100 + 32'(k));
         if (k >= 1 && k <= 16) begin
            check($sformatf("sweep_lat1_%0d", k), dout1, 32'h100 + 32'(k - 1));
            check($sformatf("sweep_ms10_%0d", k), dout10,
                  (k - 1 < 10) ? 32'h100 + 32'(k - 1) : 32'h0);
         end
         if (k >= 2)
            check($sformatf("sweep_lat2_%0d", k), dout2, 32'h100 + 32'(k - 2));
         tick();
      end

      // Read-during-write to the same address is read-first.
      we    = 1'b1;
      waddr = 4'd5;
      din   = 32'h11;
      tick();
      din   = 32'h22;
      raddr = 4'd5;
      #1;
      check("rdw_lat0_before", dout0, 32'h11);
      tick();
      we = 1'b0;
      check("rdw_lat0_after", dout0, 32'h22);
      check("rdw_lat1_old", dout1, 32'h11);
      tick();
      check("rdw_lat1_new", dout1, 32'h22);
      check("rdw_lat2_old", dout2, 32'h11);
      tick();
      check("rdw_lat2_new", dout2, 32'h22);

      // Out-of-range write to 12 must not alias into a 10-word array.
      we    = 1'b1;
      waddr = 4'd12;
      din   = 32'hAA;
      tick();
      we    = 1'b0;
      raddr = 4'd2;
      tick();
      check("oor_ms10_addr2", dout10, 32'h102);
      raddr = 4'd4;
      tick();
      check("oor_ms10_addr4", dout10, 32'h104);
      raddr = 4'd12;
      #1;
      check("oor_lat0_addr12", dout0, 32'hAA);
      tick();
      check("oor_ms10_read12", dout10, 32'h0);
      check("oor_lat1_addr12", dout1, 32'hAA);

      // Reset mid-stream with reads in flight, plus a write attempted in reset.
      raddr = 4'd7;
      tick();
      raddr = 4'd8;
      tick();
      check("mid_lat2_inflight", dout2, 32'h107);
      rstn  = 1'b0;
      we    = 1'b1;
      waddr = 4'd1;
      din   = 32'h55;
      raddr = 4'd9;
      #1;
      check("mid_lat0_in_reset", dout0, 32'h109);
      tick();
      rstn  = 1'b1;
      we    = 1'b0;
      raddr = 4'd10;
      #1;
      check("mid_lat2_rel0", dout2, 32'h0);
      check("mid_lat1_rel0", dout1, 32'h0);
      check("mid_lat0_rel0", dout0, 32'h10A);
      tick();
      check("mid_lat2_rel1", dout2, 32'h0);
      check("mid_lat1_rel1", dout1, 32'h10A);
      raddr = 4'd11;
      tick();
      check("mid_lat2_rel2", dout2, 32'h10A);
      tick();
      check("mid_lat2_rel3", dout2, 32'h10B);

      // Address 1 keeps its value after the write attempted during reset.
      raddr = 4'd1;
      #1;
      check("rstwr_lat0", dout0, 32'h101);
      tick();
      check("rstwr_lat1", dout1, 32'h101);
      check("rstwr_ms10", dout10, 32'h101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
